// File: rtl/ray_gen.sv
// Primary-ray generator: walks the screen in raster order and emits one
// camera-space ray direction (col - H_RES/2, V_RES/2 - row, FOCAL) per pixel.
module ray_gen #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int FOCAL   = 256,
  parameter int COORD_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       ray_valid,
  input  logic                       ray_ready,
  output logic signed [COORD_W-1:0]  ray_x,
  output logic signed [COORD_W-1:0]  ray_y,
  output logic signed [COORD_W-1:0]  ray_z,
  output logic [$clog2(H_RES)-1:0]   col,
  output logic [$clog2(V_RES)-1:0]   row,
  output logic                       ray_last,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int CW = $clog2(H_RES);
  localparam int RW = $clog2(V_RES);

  localparam logic [CW-1:0] COL_MAX = CW'(H_RES - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_RES - 1);

  localparam logic signed [COORD_W-1:0] H_HALF  = COORD_W'(H_RES / 2);
  localparam logic signed [COORD_W-1:0] V_HALF  = COORD_W'(V_RES / 2);
  localparam logic signed [COORD_W-1:0] FOCAL_C = COORD_W'(FOCAL);
  localparam logic signed [COORD_W-1:0] ZERO_C  = '0;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic          handshake;
  logic [CW-1:0] next_col;
  logic [RW-1:0] next_row;

  assign ray_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign handshake = ray_valid & ray_ready;

  // Raster advance; wrap is an explicit compare so odd resolutions work.
  always_comb begin
    next_col = col;
    next_row = row;
    if (col == COL_MAX) begin
      next_col = '0;
      next_row = row + 1'b1;
    end else begin
      next_col = col + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      ray_x      <= '0;
      ray_y      <= '0;
      ray_z      <= '0;
      ray_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            col      <= '0;
            row      <= '0;
            ray_x    <= ZERO_C - H_HALF;
            ray_y    <= V_HALF;
            ray_z    <= FOCAL_C;
            ray_last <= (COL_MAX == '0) && (ROW_MAX == '0);
          end
        end
        RUN: begin
          if (handshake) begin
            if (ray_last) begin
              state      <= IDLE;
              frame_done <= 1'b1;
              col        <= '0;
              row        <= '0;
              ray_x      <= '0;
              ray_y      <= '0;
              ray_z      <= '0;
              ray_last   <= 1'b0;
            end else begin
              col      <= next_col;
              row      <= next_row;
              ray_x    <= COORD_W'(next_col) - H_HALF;
              ray_y    <= V_HALF - COORD_W'(next_row);
              ray_last <= (next_col == COL_MAX) && (next_row == ROW_MAX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_gen.sv
// Scoreboard bench for ray_gen: a small 4x2 instance and a 10x6 instance,
// expected rays come from a raster-order model pushed into per-DUT queues.
module tb_ray_gen;

  typedef struct {
    int x;
    int y;
    int z;
    int c;
    int r;
    int l;
  } ray_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ray_ready;
  logic ray_valid, ray_last, busy, frame_done;
  logic signed [11:0] ray_x, ray_y, ray_z;
  logic [1:0] col;
  logic [0:0] row;

  logic start2, ready2;
  logic valid2, last2, busy2, done2;
  logic signed [7:0] x2, y2, z2;
  logic [3:0] col2;
  logic [2:0] row2;

  ray_gen #(.H_RES(4), .V_RES(2), .FOCAL(8), .COORD_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_x(ray_x), .ray_y(ray_y), .ray_z(ray_z), .col(col), .row(row),
    .ray_last(ray_last), .busy(busy), .frame_done(frame_done));

  ray_gen #(.H_RES(10), .V_RES(6), .FOCAL(100), .COORD_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ray_valid(valid2), .ray_ready(ready2),
    .ray_x(x2), .ray_y(y2), .ray_z(z2), .col(col2), .row(row2),
    .ray_last(last2), .busy(busy2), .frame_done(done2));

  int n_chk = 0;
  int n_fail = 0;
  ray_t q1[$];
  ray_t q2[$];
  int acc1 = 0, acc2 = 0, done_cnt1 = 0, done_cnt2 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every pixel in raster order, direction from the camera model.
  function automatic void push_frame(input int which, input int h, input int v, input int f);
    ray_t e;
    for (int r = 0; r < v; r++) begin
      for (int c = 0; c < h; c++) begin
        e.x = c - h / 2;
        e.y = v / 2 - r;
        e.z = f;
        e.c = c;
        e.r = r;
        e.l = (c == h - 1 && r == v - 1) ? 1 : 0;
        if (which == 0) q1.push_back(e);
        else q2.push_back(e);
      end
    end
  endfunction

  // Monitor for the 4x2 instance.
  logic held = 1'b0;
  logic pend_done = 1'b0;
  int   sx, sy, sz, sc, sr, sl;
  always @(negedge clk) begin
    ray_t e;
    if (rst) begin
      held = 1'b0;
      pend_done = 1'b0;
    end else begin
      chk("busy_eq_valid", busy, ray_valid);
      if (!ray_valid) chk("z_zero_idle", ray_z, 0);
      if (frame_done) done_cnt1++;
      chk("frame_done", frame_done, pend_done ? 1 : 0);
      pend_done = 1'b0;
      if (held) begin
        chk("hold_x", ray_x, sx);
        chk("hold_y", ray_y, sy);
        chk("hold_z", ray_z, sz);
        chk("hold_col", col, sc);
        chk("hold_row", row, sr);
        chk("hold_last", ray_last, sl);
      end
      if (ray_valid && ray_ready) begin
        if (q1.size() == 0) begin
          chk("unexpected_ray", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("ray_x", ray_x, e.x);
          chk("ray_y", ray_y, e.y);
          chk("ray_z", ray_z, e.z);
          chk("col", col, e.c);
          chk("row", row, e.r);
          chk("ray_last", ray_last, e.l);
          acc1++;
          if (e.l != 0) pend_done = 1'b1;
        end
      end
      sx = ray_x; sy = ray_y; sz = ray_z; sc = col; sr = row; sl = ray_last;
      held = ray_valid && !ray_ready;
    end
  end

  // Monitor for the 10x6 instance.
  always @(negedge clk) begin
    ray_t e;
    if (!rst) begin
      if (done2) done_cnt2++;
      if (valid2 && ready2) begin
        if (q2.size() == 0) begin
          chk("unexpected_ray2", 1, 0);
        end else begin
          e = q2.pop_front();
          chk("ray2_x", x2, e.x);
          chk("ray2_y", y2, e.y);
          chk("ray2_z", z2, e.z);
          chk("col2", col2, e.c);
          chk("row2", row2, e.r);
          chk("ray2_last", last2, e.l);
          acc2++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    push_frame(0, 4, 2, 8);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("valid_latency", ray_valid, 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      cyc();
      k++;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    int a0, d0, cycles, k;
    rst = 1'b1; start = 1'b0; ray_ready = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_valid", ray_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", ray_last, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_x", ray_x, 0);
    chk("rst_y", ray_y, 0);

    // Back-to-back frame and its length.
    ray_ready = 1'b1;
    start_frame();
    chk("first_x", ray_x, -2);
    chk("first_y", ray_y, 1);
    cycles = 0;
    while (!frame_done && cycles < 50) begin
      cyc();
      cycles++;
    end
    chk("frame_cycles", cycles, 8);
    cyc();

    // Backpressure pattern 1,0,0,1.
    a0 = acc1;
    start_frame();
    k = 0;
    while (busy && k < 200) begin
      ray_ready = (k % 4 == 0) || (k % 4 == 3);
      cyc();
      k++;
    end
    chk("bp_timeout", busy, 0);
    chk("bp_accepted", acc1 - a0, 8);

    // start while running and on the final handshake is ignored.
    ray_ready = 1'b1;
    cyc();
    a0 = acc1;
    d0 = done_cnt1;
    start_frame();
    cyc(); cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (!ray_last && k < 50) begin
      cyc();
      k++;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("no_queued_start", busy, 0);
    chk("restart_accepted", acc1 - a0, 8);
    chk("single_done", done_cnt1 - d0, 1);

    // Reset mid-frame.
    a0 = acc1;
    start_frame();
    k = 0;
    while (acc1 - a0 < 5 && k < 50) begin
      cyc();
      k++;
    end
    chk("pre_reset_acc", acc1 - a0, 5);
    d0 = done_cnt1;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ray_valid, 0);
    chk("arst_col", col, 0);
    chk("arst_row", row, 0);
    chk("arst_busy", busy, 0);
    q1.delete();
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("no_done_on_reset", done_cnt1 - d0, 0);
    a0 = acc1;
    start_frame();
    chk("post_rst_x", ray_x, -2);
    chk("post_rst_y", ray_y, 1);
    chk("post_rst_z", ray_z, 8);
    wait_idle("post_rst_timeout", 50);
    chk("post_rst_acc", acc1 - a0, 8);

    // Random backpressure with stray start pulses.
    for (int f = 0; f < 4; f++) begin
      a0 = acc1;
      start_frame();
      k = 0;
      while (busy && k < 300) begin
        ray_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 5) == 0);
        cyc();
        k++;
      end
      start = 1'b0;
      chk("rand_timeout", busy, 0);
      chk("rand_accepted", acc1 - a0, 8);
      cyc();
    end
    chk("q1_empty", q1.size(), 0);

    // Non-power-of-two instance: frame length then random ready.
    ready2 = 1'b1;
    push_frame(1, 10, 6, 100);
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    chk("valid2_latency", valid2, 1);
    cycles = 0;
    while (!done2 && cycles < 200) begin
      cyc();
      cycles++;
    end
    chk("frame2_cycles", cycles, 60);
    cyc();
    a0 = acc2;
    d0 = done_cnt2;
    push_frame(1, 10, 6, 100);
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    k = 0;
    while (busy2 && k < 1000) begin
      ready2 = $urandom_range(0, 1);
      cyc();
      k++;
    end
    cyc();
    chk("frame2_timeout", busy2, 0);
    chk("frame2_accepted", acc2 - a0, 60);
    chk("frame2_done", done_cnt2 - d0, 1);
    chk("q2_empty", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
